// File: rtl/wb_mtimer_pkg.sv
// Shared constants for the Wishbone RISC-V machine timer: register offsets,
// CTRL bit positions, reset values and the byte-lane write merge helper.
package wb_mtimer_pkg;

  localparam logic [2:0] MTIMER_MTIME_LO    = 3'd0;
  localparam logic [2:0] MTIMER_MTIME_HI    = 3'd1;
  localparam logic [2:0] MTIMER_MTIMECMP_LO = 3'd2;
  localparam logic [2:0] MTIMER_MTIMECMP_HI = 3'd3;
  localparam logic [2:0] MTIMER_CTRL        = 3'd4;
  localparam logic [2:0] MTIMER_PRESCALE    = 3'd5;

  localparam int MTIMER_CTRL_EN = 0;

  localparam logic [15:0] MTIMER_PRESCALE_RST = 16'd0;
  localparam logic [63:0] MTIMER_CMP_RST      = 64'hFFFF_FFFF_FFFF_FFFF;

  function automatic logic [31:0] mtimer_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  sel);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mtimer_prescaler.sv
// Prescaler for the machine timer: emits one tick every (prescale + 1) enabled
// cycles; a clear restarts the count without swallowing a coincident tick.
module mtimer_prescaler (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_en,
  input  logic [15:0] i_prescale,
  input  logic        i_clr,
  output logic        o_tick
);

  logic [15:0] r_pcnt;

  assign o_tick = i_en & (r_pcnt == i_prescale);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pcnt <= '0;
    end else if (i_clr || o_tick) begin
      r_pcnt <= '0;
    end else if (i_en) begin
      r_pcnt <= r_pcnt + 16'd1;
    end
  end

endmodule

// File: rtl/wb_mtimer.sv
// Wishbone machine timer: 64-bit mtime/mtimecmp, prescaled tick, shadowed
// atomic HI read and a registered level interrupt for the CPU.
module wb_mtimer
  import wb_mtimer_pkg::*;
#(
  parameter logic [15:0] PRESCALE_RST = MTIMER_PRESCALE_RST,
  parameter logic [63:0] CMP_RST      = MTIMER_CMP_RST
) (
  input  logic        wb_clk,
  input  logic        wb_rst_n,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic [2:0]  wb_cti_i,
  input  logic [1:0]  wb_bte_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        wb_rty_o,
  output logic        timer_int_o
);

  logic [63:0] r_mtime, r_cmp, w_mtime_d, w_cmp_d;
  logic [31:0] r_hi_shadow, r_dat, w_rdata;
  logic [15:0] r_prescale;
  logic        r_en, r_ack, r_err, r_int;
  logic [2:0]  w_off;
  logic        w_req, w_unmapped, w_wr, w_rd, w_tick, w_mtime_wr, w_pre_wr;
  logic        w_unused;

  assign w_unused = ^{wb_cti_i, wb_bte_i, wb_adr_i[31:5], wb_adr_i[1:0]};

  assign w_off      = wb_adr_i[4:2];
  // A request is not re-sampled in the cycle its response is on the bus.
  assign w_req      = wb_cyc_i & wb_stb_i & ~r_ack & ~r_err;
  assign w_unmapped = (w_off == 3'd6) | (w_off == 3'd7);
  assign w_wr       = w_req & wb_we_i & ~w_unmapped;
  assign w_rd       = w_req & ~wb_we_i & ~w_unmapped;
  assign w_mtime_wr = w_wr & ((w_off == MTIMER_MTIME_LO) | (w_off == MTIMER_MTIME_HI));
  assign w_pre_wr   = w_wr & (w_off == MTIMER_PRESCALE);

  mtimer_prescaler u_prescaler (
    .i_clk      (wb_clk),
    .i_rst_n    (wb_rst_n),
    .i_en       (r_en),
    .i_prescale (r_prescale),
    .i_clr      (w_pre_wr),
    .o_tick     (w_tick)
  );

  always_comb begin
    w_mtime_d = r_mtime;
    w_cmp_d   = r_cmp;
    if (w_wr) begin
      case (w_off)
        MTIMER_MTIME_LO:    w_mtime_d[31:0]  = mtimer_merge(r_mtime[31:0], wb_dat_i, wb_sel_i);
        MTIMER_MTIME_HI:    w_mtime_d[63:32] = mtimer_merge(r_mtime[63:32], wb_dat_i, wb_sel_i);
        MTIMER_MTIMECMP_LO: w_cmp_d[31:0]    = mtimer_merge(r_cmp[31:0], wb_dat_i, wb_sel_i);
        MTIMER_MTIMECMP_HI: w_cmp_d[63:32]   = mtimer_merge(r_cmp[63:32], wb_dat_i, wb_sel_i);
        default: ;
      endcase
    end
    // A bus write to either mtime half drops this cycle's tick.
    if (w_tick && !w_mtime_wr) w_mtime_d = r_mtime + 64'd1;
  end

  always_comb begin
    w_rdata = '0;
    case (w_off)
      MTIMER_MTIME_LO:    w_rdata = r_mtime[31:0];
      MTIMER_MTIME_HI:    w_rdata = r_hi_shadow;
      MTIMER_MTIMECMP_LO: w_rdata = r_cmp[31:0];
      MTIMER_MTIMECMP_HI: w_rdata = r_cmp[63:32];
      MTIMER_CTRL:        w_rdata[MTIMER_CTRL_EN] = r_en;
      MTIMER_PRESCALE:    w_rdata = {16'd0, r_prescale};
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_mtime     <= '0;
      r_cmp       <= CMP_RST;
      r_hi_shadow <= '0;
      r_prescale  <= PRESCALE_RST;
      r_en        <= 1'b1;
      r_ack       <= 1'b0;
      r_err       <= 1'b0;
      r_dat       <= '0;
      r_int       <= 1'b0;
    end else begin
      r_ack   <= w_req & ~w_unmapped;
      r_err   <= w_req & w_unmapped;
      r_dat   <= w_rd ? w_rdata : '0;
      r_mtime <= w_mtime_d;
      r_cmp   <= w_cmp_d;
      r_int   <= (r_mtime >= r_cmp);
      if (w_rd && (w_off == MTIMER_MTIME_LO)) r_hi_shadow <= r_mtime[63:32];
      if (w_wr && (w_off == MTIMER_CTRL) && wb_sel_i[0]) r_en <= wb_dat_i[MTIMER_CTRL_EN];
      if (w_pre_wr) begin
        if (wb_sel_i[0]) r_prescale[7:0]  <= wb_dat_i[7:0];
        if (wb_sel_i[1]) r_prescale[15:8] <= wb_dat_i[15:8];
      end
    end
  end

  assign wb_dat_o    = r_dat;
  assign wb_ack_o    = r_ack;
  assign wb_err_o    = r_err;
  assign wb_rty_o    = 1'b0;
  assign timer_int_o = r_int;

endmodule

// File: tb/tb_wb_mtimer.sv
// Directed plus randomized bench for wb_mtimer; mtime is predicted from the
// enable edge, base value and prescale by plain division, not by cycle stepping.
module tb_wb_mtimer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] adr = '0, dat_w = '0, dat_r;
  logic [3:0]  sel = '0;
  logic        we = 1'b0, cyc = 1'b0, stb = 1'b0;
  logic [2:0]  cti = '0;
  logic [1:0]  bte = '0;
  logic        ack_o, err_o, rty_o, irq_o;

  wb_mtimer dut (
    .wb_clk      (clk),
    .wb_rst_n    (rst_n),
    .wb_adr_i    (adr),
    .wb_dat_i    (dat_w),
    .wb_sel_i    (sel),
    .wb_we_i     (we),
    .wb_cyc_i    (cyc),
    .wb_stb_i    (stb),
    .wb_cti_i    (cti),
    .wb_bte_i    (bte),
    .wb_dat_o    (dat_r),
    .wb_ack_o    (ack_o),
    .wb_err_o    (err_o),
    .wb_rty_o    (rty_o),
    .timer_int_o (irq_o)
  );

  always #5 clk = ~clk;

  int unsigned edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] rd;
  logic        ack, err, irq;
  int unsigned e_acc, e_en;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // mtime after clock edge e, given enable at edge e1 with pcnt cleared.
  function automatic logic [63:0] model_mtime(input logic [63:0] base, input int unsigned e,
                                              input int unsigned e1, input int unsigned p);
    return base + 64'((e - e1) / (p + 1));
  endfunction

  task automatic bus(input logic [2:0] off, input logic w, input logic [31:0] d,
                     input logic [3:0] s);
    @(posedge clk); #1;
    adr = {27'd0, off, 2'b00}; we = w; dat_w = d; sel = s; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    rd = dat_r; ack = ack_o; err = err_o; irq = irq_o; e_acc = edge_cnt;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input string tag, input logic [2:0] off, input logic [31:0] d,
                    input logic [3:0] s);
    bus(off, 1'b1, d, s);
    check(tag, ack, 1'b1);
  endtask

  task automatic rd_check(input string tag, input logic [2:0] off, input logic [31:0] exp);
    bus(off, 1'b0, '0, 4'hF);
    check(tag, rd, exp);
  endtask

  // Freeze, load mtime/mtimecmp/prescale, then enable; e_en is the enable edge.
  task automatic setup(input logic [63:0] base, input logic [63:0] cmp, input int unsigned p);
    bus(3'd4, 1'b1, 32'd0, 4'hF);
    bus(3'd0, 1'b1, base[31:0], 4'hF);
    bus(3'd1, 1'b1, base[63:32], 4'hF);
    bus(3'd3, 1'b1, 32'hFFFF_FFFF, 4'hF);
    bus(3'd2, 1'b1, cmp[31:0], 4'hF);
    bus(3'd3, 1'b1, cmp[63:32], 4'hF);
    bus(3'd5, 1'b1, p, 4'hF);
    wr("enable_ack", 3'd4, 32'd1, 4'hF);
    e_en = e_acc;
  endtask

  initial begin
    logic [63:0] base, cmp, exp_m;
    int unsigned ea, er, eh, ef, p;
    bit          seen;

    #12;
    check("rst_ack", ack_o, 1'b0);
    check("rst_err", err_o, 1'b0);
    check("rst_dat", dat_r, 32'd0);
    check("rst_int", irq_o, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    ea = edge_cnt;

    bus(3'd0, 1'b0, '0, 4'hF);
    check("rst_mtime_lo", rd, model_mtime(64'd0, e_acc - 1, ea - 1, 0) & 64'hFFFF_FFFF);
    rd_check("rst_mtime_hi", 3'd1, 32'd0);
    rd_check("rst_cmp_lo", 3'd2, 32'hFFFF_FFFF);
    rd_check("rst_cmp_hi", 3'd3, 32'hFFFF_FFFF);
    rd_check("rst_ctrl", 3'd4, 32'd1);
    rd_check("rst_prescale", 3'd5, 32'd0);
    check("rst_int_run", irq_o, 1'b0);
    bus(3'd6, 1'b0, '0, 4'hF);
    check("unmapped_err", err, 1'b1);
    check("unmapped_ack", ack, 1'b0);
    check("unmapped_dat", rd, 32'd0);
    bus(3'd7, 1'b1, 32'hFFFF_FFFF, 4'hF);
    check("unmapped_wr_err", err, 1'b1);

    // Prescale 3, compare 10: interrupt edge follows the 10th tick by one cycle.
    setup(64'd0, 64'd10, 3);
    seen = 1'b0; er = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk); #1;
      if (irq_o === 1'b1) begin seen = 1'b1; er = edge_cnt; end
    end
    check("int_rise_seen", seen, 1'b1);
    check("int_rise_latency", er - e_en, 41);
    wr("freeze_ack", 3'd4, 32'd0, 4'hF);
    ef = e_acc;
    exp_m = model_mtime(64'd0, ef, e_en, 3);
    rd_check("frozen_lo_a", 3'd0, exp_m[31:0]);
    repeat (100) @(posedge clk);
    rd_check("frozen_lo_b", 3'd0, exp_m[31:0]);
    check("frozen_int", irq_o, 1'b1);

    // LO->HI carry observed through the shadow register.
    setup(64'h0000_0000_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    @(posedge clk);
    bus(3'd0, 1'b0, '0, 4'hF);
    exp_m = model_mtime(64'h0000_0000_FFFF_FFFE, e_acc - 1, e_en, 0);
    check("carry_lo", rd, exp_m[31:0]);
    check("carry_lo_zero", rd, 32'd0);
    rd_check("carry_hi_shadow", 3'd1, exp_m[63:32]);

    for (int it = 0; it < 8; it++) begin
      base = {$urandom(), 32'hFFFF_FFE0 | 32'($urandom_range(0, 31))};
      if (it == 0) base[63:32] = 32'hFFFF_FFFF;
      cmp  = base + 64'($urandom_range(0, 24));
      p    = $urandom_range(0, 3);
      setup(base, cmp, p);
      repeat ($urandom_range(0, 30)) @(posedge clk);
      bus(3'd0, 1'b0, '0, 4'hF);
      er = e_acc;
      exp_m = model_mtime(base, er - 1, e_en, p);
      check("rand_lo", rd, exp_m[31:0]);
      check("rand_int_lo", irq, exp_m >= cmp);
      repeat ($urandom_range(0, 5)) @(posedge clk);
      bus(3'd1, 1'b0, '0, 4'hF);
      eh = e_acc;
      check("rand_hi_shadow", rd, exp_m[63:32]);
      check("rand_int_hi", irq, model_mtime(base, eh - 1, e_en, p) >= cmp);
    end

    // Wrap to zero drops the interrupt against compare 5.
    setup(64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 0);
    @(posedge clk); #1;
    check("wrap_int_before", irq_o, 1'b1);
    @(posedge clk); #1;
    check("wrap_int_after", irq_o, 1'b0);

    wr("cmp_full_ack", 3'd2, 32'h1234_5678, 4'hF);
    wr("cmp_byte_ack", 3'd2, 32'h0000_AB00, 4'b0010);
    rd_check("cmp_byte_lo", 3'd2, 32'h1234_AB78);
    rd_check("cmp_byte_hi", 3'd3, 32'd0);

    // Held read request: one ack every second cycle, then reset mid-ack.
    @(posedge clk); #1;
    adr = {27'd0, 3'd4, 2'b00}; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i != 0) begin @(posedge clk); #1; end
      check($sformatf("held_ack_%0d", i), ack_o, (i % 2) == 1);
    end
    rst_n = 1'b0;
    #1;
    check("rst_mid_ack", ack_o, 1'b0);
    check("rst_mid_dat", dat_r, 32'd0);
    cyc = 1'b0; stb = 1'b0;
    #3;
    rst_n = 1'b1;
    rd_check("post_rst_cmp_lo", 3'd2, 32'hFFFF_FFFF);
    rd_check("post_rst_ctrl", 3'd4, 32'd1);
    rd_check("post_rst_prescale", 3'd5, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
